// File: rtl/mem_defs.sv
// Shared definitions for the memory stage: FSM states, access kinds and control-word bit map.
package mem_defs;

    localparam int CTRL_W = 33;

    // Positions of the memory-op fields inside the 33-bit control word
    localparam int CTRL_MEM_READ_B  = 0;
    localparam int CTRL_MEM_READ_W  = 1;
    localparam int CTRL_MEM_WRITE_B = 2;
    localparam int CTRL_MEM_WRITE_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        RB   = 3'd1,
        RW   = 3'd2,
        WB   = 3'd3,
        WW   = 3'd4
    } acc_t;

    // Write beats read, word beats byte
    function automatic acc_t acc_kind(input logic rb, input logic rw,
                                      input logic wb, input logic ww);
        acc_t k;
        if (ww)      k = WW;
        else if (wb) k = WB;
        else if (rw) k = RW;
        else if (rb) k = RB;
        else         k = NONE;
        return k;
    endfunction

    function automatic logic acc_is_word(input acc_t k);
        return (k == RW) || (k == WW);
    endfunction

    function automatic logic acc_is_write(input acc_t k);
        return (k == WB) || (k == WW);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_decode.sv
// Extracts the memory-op fields from the registered control word of the ALU stage.
module ctrl_decode
    import mem_defs::*;
(
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_mem_read_b,
    output logic              o_mem_read_w,
    output logic              o_mem_write_b,
    output logic              o_mem_write_w
);

    assign o_mem_read_b  = i_ctrl[CTRL_MEM_READ_B];
    assign o_mem_read_w  = i_ctrl[CTRL_MEM_READ_W];
    assign o_mem_write_b = i_ctrl[CTRL_MEM_WRITE_B];
    assign o_mem_write_w = i_ctrl[CTRL_MEM_WRITE_W];

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: byte/word loads and stores over an 8-bit req/ack bus.
// Optional misaligned-word fault when MEM_STAGE_ALIGN_CHECK_EN is defined.
module mem_stage
    import mem_defs::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_signals_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [15:0]       wdata_in,
    input  logic [15:0]       pc_in,
    input  logic [15:0]       imm_in,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              out_valid,
    output logic [15:0]       rdata_out,
    output logic [CTRL_W-1:0] control_signals_out,
    output logic [15:0]       pc_out,
    output logic [15:0]       imm_out,
    output logic              fault_out,
    output logic [1:0]        dbg_state
);

    state_t              r_state;
    state_t              w_state_nxt;
    acc_t                r_kind;
    acc_t                w_kind;
    logic                w_rb;
    logic                w_rw;
    logic                w_wb;
    logic                w_ww;
    logic                w_accept;
    logic                w_misalign;
    logic                w_start_bus;
    logic [7:0]          r_wdata_hi;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [7:0]          r_bus_wdata;
    logic                r_out_valid;
    logic [15:0]         r_rdata;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [15:0]         r_pc;
    logic [15:0]         r_imm;
    logic                r_fault;

    ctrl_decode u_ctrl_decode (
        .i_ctrl        (control_signals_in),
        .o_mem_read_b  (w_rb),
        .o_mem_read_w  (w_rw),
        .o_mem_write_b (w_wb),
        .o_mem_write_w (w_ww)
    );

    assign w_kind   = acc_kind(w_rb, w_rw, w_wb, w_ww);
    assign w_accept = in_valid && (r_state == IDLE);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misalign = acc_is_word(w_kind) && addr_in[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start_bus = w_accept && (w_kind != NONE) && !w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_bus)
                    w_state_nxt = ACC_LO;
            end
            ACC_LO: begin
                if (bus_ack)
                    w_state_nxt = acc_is_word(r_kind) ? ACC_HI : IDLE;
            end
            ACC_HI: begin
                if (bus_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind      <= NONE;
            r_wdata_hi  <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_out_valid <= 1'b0;
            r_rdata     <= '0;
            r_ctrl      <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ctrl  <= control_signals_in;
                        r_pc    <= pc_in;
                        r_imm   <= imm_in;
                        r_rdata <= '0;
                        r_kind  <= w_kind;
                        if (w_start_bus) begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= acc_is_write(w_kind);
                            r_bus_addr  <= addr_in;
                            r_bus_wdata <= wdata_in[7:0];
                            r_wdata_hi  <= wdata_in[15:8];
                        end else begin
                            r_out_valid <= 1'b1;
                            r_fault     <= w_misalign;
                        end
                    end
                end
                ACC_LO: begin
                    if (bus_ack) begin
                        if (!acc_is_write(r_kind))
                            r_rdata[7:0] <= bus_rdata;
                        if (acc_is_word(r_kind)) begin
                            // Natural ADDR_W-bit overflow gives the wrap to zero
                            r_bus_addr  <= r_bus_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            r_bus_wdata <= r_wdata_hi;
                        end else begin
                            r_bus_req   <= 1'b0;
                            r_bus_we    <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ACC_HI: begin
                    if (bus_ack) begin
                        if (!acc_is_write(r_kind))
                            r_rdata[15:8] <= bus_rdata;
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_bus_we  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready            = (r_state == IDLE);
    assign dbg_state           = r_state;
    assign bus_req             = r_bus_req;
    assign bus_we              = r_bus_we;
    assign bus_addr            = r_bus_addr;
    assign bus_wdata           = r_bus_wdata;
    assign out_valid           = r_out_valid;
    assign rdata_out           = r_rdata;
    assign control_signals_out = r_ctrl;
    assign pc_out              = r_pc;
    assign imm_out             = r_imm;
    assign fault_out           = r_fault;

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline stage after the ALU stage. It consumes that stage's registered control word, ALU result (address), store data, PC and immediate, and performs byte or word loads and stores over an 8-bit request/acknowledge memory bus, splitting each word into two byte transactions. It stalls the ALU stage while a bus access is in flight and hands load data plus forwarded fields to writeback with a one-cycle valid pulse.

## Interface
Parameters:
- ADDR_W, 16, address width for `addr_in` and `bus_addr`.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept; stall to the ALU stage when low.
- control_signals_in  in  33  control word; decoded by ctrl_decode.
- addr_in  in  ADDR_W  effective address (ALU result).
- wdata_in  in  16  store data.
- pc_in, imm_in  in  16 each  forwarded unchanged.
- bus_req  out  1  bus request, held until acknowledged.
- bus_we  out  1  1 = write byte.
- bus_addr  out  ADDR_W  byte address.
- bus_wdata  out  8  write byte.
- bus_rdata  in  8  read byte, valid when bus_ack is high.
- bus_ack  in  1  completes the current byte.
- out_valid  out  1  one-cycle pulse; all `*_out` fields are valid.
- rdata_out  out  16  load result.
- control_signals_out  out  33  forwarded control word.
- pc_out, imm_out  out  16 each  forwarded fields.
- fault_out  out  1  misaligned-word fault (see Configuration).
- dbg_state  out  2  current FSM state.

## Operation
- Decoded op fields: memReadB, memReadW, memWriteB, memWriteW.
- Priority when several are set: write beats read; word beats byte.
- FSM states: IDLE=0, ACC_LO=1, ACC_HI=2.
- in_ready = (state == IDLE).
- Accept = in_valid & in_ready at a rising edge.
- Accept with no memory op:
  - Forwarded fields are registered, rdata_out is set to 0, out_valid pulses.
  - State stays IDLE.
- Accept with a memory op:
  - Latch the op, address, write data and forwarded fields; go to ACC_LO.
  - Drive bus_req=1, bus_addr=addr_in, bus_we=write.
  - Store byte sent first is wdata_in[7:0].
- ACC_LO, on an edge with bus_ack=1:
  - Read: capture bus_rdata into rdata_out[7:0].
  - Byte op: rdata_out[15:8]=0 (zero-extend); finish.
  - Word op: bus_addr <= addr+1, wrapping 0xFFFF to 0x0000; bus_wdata <= wdata[15:8]; go to ACC_HI with bus_req held high.
- ACC_HI, on an edge with bus_ack=1:
  - Read: capture bus_rdata into rdata_out[15:8].
  - Finish.
- Finish:
  - bus_req <= 0, bus_we <= 0, state <= IDLE.
  - out_valid pulses for one cycle.
  - A write reports rdata_out = 0.
- Word byte order is little-endian: low byte at addr, high byte at addr+1.
- bus_ack while bus_req is low is ignored.
- No bus timeout: the stage waits indefinitely for bus_ack.
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, out_valid 0, rdata_out 0, control_signals_out 0, pc_out 0, imm_out 0, fault_out 0.
- Reset mid-access:
  - bus_req drops immediately (asynchronous).
  - The transaction is abandoned; no out_valid.
  - A late bus_ack after reset is ignored.

## Timing
- All outputs are registered; in_ready and dbg_state are decoded from the state register.
- Non-memory op accepted at edge N: out_valid is high for cycle N..N+1; in_ready stays high, so back-to-back accepts are allowed.
- Memory op accepted at edge N: bus_req rises after edge N.
- Byte op: ack sampled at edge N+k (k ≥ 1); out_valid is high in the following cycle; in_ready returns high after that same edge.
- Word op: two acks, each at least one cycle apart; minimum latency is 2 cycles from accept to out_valid.
- A new accept can occur on the very edge that out_valid is asserted for the previous op.
- No downstream backpressure: writeback always accepts out_valid.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN defined:
  - A word op with addr_in[0]=1 issues no bus cycle.
  - It completes at the next edge with out_valid=1, fault_out=1, rdata_out=0.
  - fault_out is otherwise 0 and pulses together with out_valid.
- Undefined:
  - Odd-address words perform two byte accesses (addr, addr+1 with wrap).
  - fault_out is tied 0.

## Structure
- Shared package/header (`mem_defs`) holds:
  - State encodings IDLE/ACC_LO/ACC_HI.
  - Access-kind constants (NONE, RB, RW, WB, WW).
- Reuse the existing ctrl_decode sub-module for field extraction.
- No other sub-modules; the FSM and datapath live in mem_stage.

## Test plan
- Non-memory control word, in_valid one cycle: out_valid next cycle, rdata_out=0x0000, pc/imm forwarded, in_ready never low.
- Byte read at 0x1234, ack after 3 cycles with bus_rdata=0xA5: bus_addr=0x1234, rdata_out=0x00A5, in_ready low for 3 cycles.
- Word write 0xBEEF at 0xFFFF (align check off): first byte 0xEF at 0xFFFF, then 0xBE at 0x0000, bus_we=1 both times, fault_out=0.
- Word read at 0x2000, immediate acks with 0x34 then 0x12: rdata_out=0x1234, 2 cycles from accept to out_valid.
- Read+write bits both set, word read at 0x0101 with MEM_STAGE_ALIGN_CHECK_EN:
  - Read+write: performs a write only.
  - Word read at 0x0101: no bus_req, fault_out=1, out_valid one cycle after accept.
- rst_n low while in ACC_HI with bus_req high: bus_req=0 immediately, state IDLE, no out_valid; a stray bus_ack afterwards has no effect.
